// File: rtl/echo_fpga12_mem_pkg.sv
// Shared definitions for the on-chip RAM arbiter slice: default bus widths,
// the read latency seen by the requesters, and the requester index type.
// ECHO_ONCHIP_ARB_RDATA_REG_EN adds a register stage on the read-data return
// path, which raises the read latency from 1 to 2 cycles.
package echo_fpga12_mem_pkg;

    localparam int DEF_ADDR_W = 13;   // 8192 words
    localparam int DEF_DATA_W = 32;

`ifdef ECHO_ONCHIP_ARB_RDATA_REG_EN
    localparam int RD_LATENCY = 2;
`else
    localparam int RD_LATENCY = 1;
`endif

    // Index of the requester that owns an access
    typedef logic [0:0] owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/echo_fpga12_onchip_mem_arbiter_if.sv
// Avalon-MM-style requester port: address/strobes/write payload from the
// requester, waitrequest and the pipelined read response back to it.
interface echo_fpga12_onchip_mem_arbiter_if
    import echo_fpga12_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DATA_W / 8
);

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    // Requester side
    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    // Arbiter side
    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/echo_fpga12_rd_track.sv
// Valid/owner shift register that follows each accepted read through the RAM
// latency so the returning data can be tagged to the requester that issued it.
// Owner bits are payload and are not cleared; only the valid bits are.
module echo_fpga12_rd_track
    import echo_fpga12_mem_pkg::*;
#(
    parameter int DEPTH = RD_LATENCY
) (
    input  logic   clk,
    input  logic   clr,
    input  logic   in_vld,
    input  owner_t in_owner,
    output logic   out_vld,
    output owner_t out_owner
);

    logic [DEPTH-1:0] vld_p;
    owner_t           own_p [DEPTH];

    // Valid bits shift one stage per cycle; clear drops everything in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Owner tags ride alongside the valid bits
    always_ff @(posedge clk) begin
        own_p[0] <= in_owner;
        for (int i = 1; i < DEPTH; i++) begin
            own_p[i] <= own_p[i-1];
        end
    end

    assign out_vld   = vld_p[DEPTH-1];
    assign out_owner = own_p[DEPTH-1];

endmodule

// File: rtl/echo_fpga12_onchip_mem_arbiter.sv
// Round-robin arbiter sharing the single-port 8192x32 on-chip RAM between the
// LVDS receive path (m0) and the Nios/echo transmit path (m1). One access per
// cycle; read responses are tagged back to the issuing requester.
// Build option: ECHO_ONCHIP_ARB_RDATA_REG_EN registers mem_readdata once more
// before it reaches the requesters (read latency 2 instead of 1).
module echo_fpga12_onchip_mem_arbiter
    import echo_fpga12_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic                              clk,
    input  logic                              reset,
    echo_fpga12_onchip_mem_arbiter_if.slave   m0,
    echo_fpga12_onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]                 mem_address,
    output logic [BE_W-1:0]                   mem_byteenable,
    output logic [DATA_W-1:0]                 mem_writedata,
    output logic                              mem_chipselect,
    output logic                              mem_write,
    output logic                              mem_clken,
    input  logic [DATA_W-1:0]                 mem_readdata
);

    logic              req0, req1;
    logic              gnt0, gnt1;
    owner_t            last_q;
    logic              rd_vld_p0;
    owner_t            rd_own_p0;
    logic              trk_vld;
    owner_t            trk_owner;
    logic [DATA_W-1:0] rdata;

    // A port with both strobes high is treated as a write
    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // Grant: lone requester wins, a tie goes to the port not served last;
    // nothing is granted while reset is held
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = (last_q == OWNER_M1);
                gnt1 = (last_q == OWNER_M0);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign m0.waitrequest = req0 & ~gnt0;
    assign m1.waitrequest = req1 & ~gnt1;

    // Steer the granted port onto the RAM; idle cycles enable no byte lanes
    always_comb begin
        mem_address    = m0.address;
        mem_writedata  = m0.writedata;
        mem_byteenable = {BE_W{1'b0}};
        if (gnt1) begin
            mem_address    = m1.address;
            mem_writedata  = m1.writedata;
            mem_byteenable = m1.byteenable;
        end else if (gnt0) begin
            mem_byteenable = m0.byteenable;
        end
    end

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_write      = (gnt0 & m0.write) | (gnt1 & m1.write);
    assign mem_clken      = 1'b1;

    // Remember who was served last; m0 wins the first tie after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWNER_M1;
        end else if (gnt0) begin
            last_q <= OWNER_M0;
        end else if (gnt1) begin
            last_q <= OWNER_M1;
        end
    end

    // ---- p0: accepted read enters the tracking pipeline ----
    assign rd_vld_p0 = (gnt0 & ~m0.write) | (gnt1 & ~m1.write);
    assign rd_own_p0 = gnt1 ? OWNER_M1 : OWNER_M0;

    echo_fpga12_rd_track #(
        .DEPTH (RD_LATENCY)
    ) u_rd_track (
        .clk       (clk),
        .clr       (reset),
        .in_vld    (rd_vld_p0),
        .in_owner  (rd_own_p0),
        .out_vld   (trk_vld),
        .out_owner (trk_owner)
    );

`ifdef ECHO_ONCHIP_ARB_RDATA_REG_EN
    logic [DATA_W-1:0] rdata_p1;

    // ---- p1: extra return-data register, aligned with the second track stage ----
    always_ff @(posedge clk) begin
        rdata_p1 <= mem_readdata;
    end

    assign rdata = rdata_p1;
`else
    assign rdata = mem_readdata;
`endif

    // Data fans out to both ports; only the owner's valid strobes. A read
    // still in flight when reset arrives never reports completion.
    assign m0.readdata      = rdata;
    assign m1.readdata      = rdata;
    assign m0.readdatavalid = trk_vld & ~reset & (trk_owner == OWNER_M0);
    assign m1.readdatavalid = trk_vld & ~reset & (trk_owner == OWNER_M1);

endmodule

// File: doc/echo_fpga12_onchip_mem_arbiter.md
# echo_fpga12_onchip_mem_arbiter

Two-requester round-robin arbiter sharing the single-port 8192×32 on-chip RAM between the LVDS receive path (m0, typically writes) and the Nios/echo transmit path (m1, typically reads). It sits between the two Avalon-MM-style requester ports and the RAM's s1 port. It issues at most one access per cycle, tracks the fixed read latency, and steers read data back to the issuing requester.

## Interface
- ADDR_W, 13, word address width (8192 words)
- DATA_W, 32, data width
- BE_W, DATA_W/8, byteenable width
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- mN_address  in  ADDR_W  requester N (N=0,1) word address
- mN_read / mN_write  in  1  request strobes, held until accepted
- mN_byteenable  in  BE_W  write byte lanes
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  returned read data
- mN_readdatavalid  out  1  one-cycle strobe qualifying mN_readdata
- mem_address  out  ADDR_W; mem_byteenable  out  BE_W; mem_writedata  out  DATA_W
- mem_chipselect / mem_write  out  1  RAM access strobes
- mem_clken  out  1  RAM clock enable, constant 1
- mem_readdata  in  DATA_W  RAM q, valid one cycle after address

## Operation
- Request active when mN_read|mN_write. If both asserted on one port, write wins; read is ignored that cycle.
- Grant combinational from requests and registered pointer `last` (last port granted):
  - one port requesting → grant it
  - both requesting → grant port != last
  - none → no grant; mem_chipselect=0, mem_write=0
- mN_waitrequest = request_N & ~grant_N. Accept = request & grant.
- Granted port's address/byteenable/writedata muxed to mem_*. mem_chipselect=1 on any grant; mem_write=1 only for a granted write. Ungranted cycles drive mem_byteenable=0.
- `last` updates to the granted port on every accept; holds otherwise.
- Read tracking: 2-bit pipeline {valid, owner} captures each accepted read. The stage output drives mN_readdatavalid for the matching owner. mem_readdata is fanned to both mN_readdata; only the owner's valid strobes.
- Back-to-back reads from either port are fully pipelined, one per cycle, with no bubbles.
- Writes produce no response.

## Timing
- Reset values: `last`=1 (m0 wins first tie), read pipeline cleared, all mN_readdatavalid=0, mem_chipselect=0, mem_write=0. mN_waitrequest follows requests combinationally, including during reset.
- During reset no request is accepted; any in-flight read is discarded and produces no readdatavalid.
- Read accepted at edge T → readdatavalid at cycle T+1 (T+2 with the configuration macro).
- Write accepted at edge T → RAM updated at edge T. A read of the same address accepted at T+1 returns new data.
- Same-cycle read and write from different ports: one is granted. Order follows round-robin.
- Fairness: under continuous contention, grants strictly alternate m0,m1,m0,…; worst-case wait is 1 cycle.

## Configuration
- ECHO_ONCHIP_ARB_RDATA_REG_EN defined:
  - mem_readdata and the valid/owner pipeline gain one register stage; read latency becomes 2 cycles.
  - Pipeline depth becomes 2 entries; throughput stays one per cycle.
  - Reset clears both stages.
- Undefined: read latency is 1 cycle, and mN_readdata is combinational from mem_readdata.

## Structure
- Shared package echo_fpga12_mem_pkg holds:
  - ADDR_W/DATA_W defaults
  - RD_LATENCY constant, conditional on the macro
  - port-index typedef (1-bit owner_t)
- One sub-module, echo_fpga12_rd_track. It is a parameterised depth-RD_LATENCY valid/owner shift register with synchronous clear.

## Test plan
- Reset, then m0 write addr 0x0010 data 0xDEADBEEF be=0xF; m1 read 0x0010 next cycle → m1_readdatavalid at +1 (+2 with macro), readdata 0xDEADBEEF; m0_readdatavalid stays 0.
- Both ports read continuously from addr 0x0001/0x0002 holding 0x11111111/0x22222222 → grants alternate m0,m1,… starting m0; each port sees waitrequest every other cycle and correctly tagged data.
- m0 byte write be=0x2 data 0x0000AB00 over 0xFFFFFFFF at 0x1FFF, then read → 0xFFFFABFF.
- m0 asserts read and write together to 0x0005 → write performed, no readdatavalid.
- Read accepted, reset asserted the following cycle → no readdatavalid on either port; after reset release, first tie goes to m0.
- m1 alone issues 4 back-to-back reads 0x0000–0x0003 → waitrequest never high, 4 consecutive readdatavalid pulses in order.
